// File: rtl/cache_pkg.sv
// Shared constants, address field positions, FSM encoding and way-index helpers
// for the cache refill controller and its victim selector.
package cache_pkg;

  localparam int WAYS      = 8;
  localparam int WAY_IDX_W = 3;
  localparam int TAG_W     = 25;
  localparam int BEATS     = 16;
  localparam int BEAT_W    = 32;
  localparam int BLOCK_W   = 512;
  localparam int CNT_W     = 4;
  localparam int PLRU_W    = 7;

  localparam int ADDR_W    = 32;
  localparam int TAG_LSB   = 7;
  localparam int SET_BIT   = 6;
  localparam int OFF_W     = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FETCH  = 2'd2,
    FILL   = 2'd3
  } refill_state_e;

  function automatic logic [WAY_IDX_W-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) idx = WAY_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [WAYS-1:0] idx_to_onehot(input logic [WAY_IDX_W-1:0] idx);
    logic [WAYS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Scan downwards so the lowest-index invalid way wins.
  function automatic logic [WAYS-1:0] first_invalid(input logic [WAYS-1:0] v);
    logic [WAYS-1:0] oh;
    oh = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!v[i]) oh = idx_to_onehot(WAY_IDX_W'(i));
    end
    return oh;
  endfunction

  // Tree nodes: 0 is the root, 1..2 the middle level, 3..6 the leaf pairs.
  // A node bit of 0 steers the victim search to the lower half.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                   input logic [WAY_IDX_W-1:0] w);
    logic [PLRU_W-1:0] r;
    logic [2:0]        n1;
    logic [2:0]        n2;
    r     = t;
    n1    = 3'd1 + {2'b00, w[2]};
    n2    = 3'd3 + {1'b0, w[2:1]};
    r[0]  = ~w[2];
    r[n1] = ~w[1];
    r[n2] = ~w[0];
    return r;
  endfunction

  function automatic logic [WAY_IDX_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
    logic       b2;
    logic       b1;
    logic       b0;
    logic [2:0] n1;
    logic [2:0] n2;
    b2 = t[0];
    n1 = 3'd1 + {2'b00, b2};
    b1 = t[n1];
    n2 = 3'd3 + {1'b0, b2, b1};
    b0 = t[n2];
    return {b2, b1, b0};
  endfunction

endpackage

// File: rtl/refill_victim_sel.sv
// Per-set replacement state and one-hot victim choice for the refill controller.
// REFILL_PLRU_EN selects a 7-bit tree pseudo-LRU per set; otherwise a 3-bit round-robin pointer.
module refill_victim_sel
  import cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_sel,
  input  logic [WAYS-1:0] valid_in,
  input  logic            hit_en,
  input  logic [WAYS-1:0] hit_way,
  input  logic            alloc_en,
  input  logic            fill_en,
  input  logic [WAYS-1:0] fill_way,
  output logic [WAYS-1:0] victim
);

  logic [WAY_IDX_W-1:0] repl_idx;

`ifdef REFILL_PLRU_EN
  logic [1:0][PLRU_W-1:0] tree_q;
  logic [1:0][PLRU_W-1:0] tree_d;
  logic                   unused_alloc;

  assign unused_alloc = alloc_en;

  always_comb begin
    tree_d = tree_q;
    if (hit_en) begin
      tree_d[set_sel] = plru_touch(tree_q[set_sel], onehot_to_idx(hit_way));
    end else if (fill_en) begin
      tree_d[set_sel] = plru_touch(tree_q[set_sel], onehot_to_idx(fill_way));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  assign repl_idx = plru_victim(tree_q[set_sel]);
`else
  logic [1:0][WAY_IDX_W-1:0] rr_q;
  logic [1:0][WAY_IDX_W-1:0] rr_d;
  logic                      unused_upd;

  assign unused_upd = ^{hit_en, hit_way, fill_en, fill_way};

  // The pointer only advances when it actually supplied the victim.
  always_comb begin
    rr_d = rr_q;
    if (alloc_en && (&valid_in)) begin
      rr_d[set_sel] = rr_q[set_sel] + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign repl_idx = rr_q[set_sel];
`endif

  assign victim = (&valid_in) ? idx_to_onehot(repl_idx) : first_invalid(valid_in);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler ahead of the 2-set, 8-way data array: fetches a 64-byte block as 16 beats,
// writes it into a victim line and stalls the CPU until the retried lookup hits (REFILL_PLRU_EN: PLRU victims).
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuReq,
  input  logic [ADDR_W-1:0]  cpuAddr,
  input  logic               cacheHit,
  input  logic [WAYS-1:0]    hitWay,
  input  logic [WAYS-1:0]    validIn,
  output logic               memReq,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic               memReady,
  input  logic [BEAT_W-1:0]  memData,
  output logic [BLOCK_W-1:0] blockData,
  output logic [TAG_W-1:0]   tag,
  output logic               valid,
  output logic [WAYS-1:0]    lineSelect,
  output logic               setSelect,
  output logic               blkWrite,
  output logic               stall
);

  // Handshakes: cpuReq/cpuAddr are held by the CPU until stall is low in LOOKUP;
  // memData is consumed only in a FETCH cycle where memReady is high, one beat per cycle.

  refill_state_e        state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 set_q, set_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic [WAYS-1:0]      victim_q, victim_d;
  logic                 mem_req_q, mem_req_d;
  logic                 blk_write_q, blk_write_d;
  logic                 valid_q, valid_d;
  logic [WAYS-1:0]      line_sel_q, line_sel_d;

  logic                 hit_upd;
  logic                 alloc_en;
  logic                 fill_upd;
  logic [WAYS-1:0]      victim;
  logic                 unused_offset;

  assign unused_offset = ^cpuAddr[OFF_W-1:0];

  refill_victim_sel u_victim_sel (
    .clk      (clk),
    .rst_n    (reset),
    .set_sel  (set_q),
    .valid_in (validIn),
    .hit_en   (hit_upd),
    .hit_way  (hitWay),
    .alloc_en (alloc_en),
    .fill_en  (fill_upd),
    .fill_way (victim_q),
    .victim   (victim)
  );

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    set_d       = set_q;
    cnt_d       = cnt_q;
    block_d     = block_q;
    victim_d    = victim_q;
    mem_req_d   = mem_req_q;
    blk_write_d = 1'b0;
    valid_d     = 1'b0;
    line_sel_d  = '0;
    hit_upd     = 1'b0;
    alloc_en    = 1'b0;
    fill_upd    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpuReq) begin
          tag_d   = cpuAddr[ADDR_W-1:TAG_LSB];
          set_d   = cpuAddr[SET_BIT];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cacheHit) begin
          hit_upd = 1'b1;
          state_d = IDLE;
        end else begin
          alloc_en  = 1'b1;
          victim_d  = victim;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (memReady) begin
          block_d[{cnt_q, 5'd0} +: BEAT_W] = memData;
          cnt_d = cnt_q + 4'd1;
          // Last beat: the fill strobes are registered so they appear exactly during FILL.
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d       = '0;
            mem_req_d   = 1'b0;
            blk_write_d = 1'b1;
            valid_d     = 1'b1;
            line_sel_d  = victim_q;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        fill_upd = 1'b1;
        state_d  = LOOKUP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      set_q       <= 1'b0;
      cnt_q       <= '0;
      block_q     <= '0;
      victim_q    <= '0;
      mem_req_q   <= 1'b0;
      blk_write_q <= 1'b0;
      valid_q     <= 1'b0;
      line_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      set_q       <= set_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      victim_q    <= victim_d;
      mem_req_q   <= mem_req_d;
      blk_write_q <= blk_write_d;
      valid_q     <= valid_d;
      line_sel_q  <= line_sel_d;
    end
  end

  assign memReq     = mem_req_q;
  assign memAddr    = {tag_q, set_q, {OFF_W{1'b0}}};
  assign blockData  = block_q;
  assign tag        = tag_q;
  assign setSelect  = set_q;
  assign valid      = valid_q;
  assign lineSelect = line_sel_q;
  assign blkWrite   = blk_write_q;

  assign stall = (state_q == FETCH) || (state_q == FILL) ||
                 ((state_q == LOOKUP) && !cacheHit);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: a behavioural set array and memory drive the DUT,
// a reference model predicts each fill and a monitor checks every block write against it.
module tb_cache_refill_ctrl;

  localparam int EXP_W = 1 + 25 + 8 + 512;

  logic         clk;
  logic         reset;
  logic         cpuReq;
  logic [31:0]  cpuAddr;
  logic         cacheHit;
  logic [7:0]   hitWay;
  logic [7:0]   validIn;
  logic         memReq;
  logic [31:0]  memAddr;
  logic         memReady;
  logic [31:0]  memData;
  logic [511:0] blockData;
  logic [24:0]  tag;
  logic         valid;
  logic [7:0]   lineSelect;
  logic         setSelect;
  logic         blkWrite;
  logic         stall;

  int checks = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      mem_q[$];
  logic [EXP_W-1:0] mon_rec;
  logic [31:0]      exp_maddr;
  int               gap_mode;
  int               mem_cyc;
  int               beats_sent;

  // Set array seen by the DUT (written from the DUT's own fill outputs).
  logic [7:0]  env_v [2];
  logic [24:0] env_t [2][8];
  // Reference model of the cache contents and round-robin pointers.
  logic [7:0]  ref_v [2];
  logic [24:0] ref_t [2][8];
  int          ref_rr [2];

  cache_refill_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpuReq     (cpuReq),
    .cpuAddr    (cpuAddr),
    .cacheHit   (cacheHit),
    .hitWay     (hitWay),
    .validIn    (validIn),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memReady   (memReady),
    .memData    (memData),
    .blockData  (blockData),
    .tag        (tag),
    .valid      (valid),
    .lineSelect (lineSelect),
    .setSelect  (setSelect),
    .blkWrite   (blkWrite),
    .stall      (stall)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- set array lookup ----------------
  always_comb begin
    cacheHit = 1'b0;
    hitWay   = '0;
    validIn  = env_v[cpuAddr[6]];
    for (int w = 0; w < 8; w++) begin
      if (env_v[cpuAddr[6]][w] && (env_t[cpuAddr[6]][w] == cpuAddr[31:7])) begin
        cacheHit  = 1'b1;
        hitWay[w] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    memReady = 1'b0;
    memData  = '0;
    mem_cyc  = 0;
    forever begin
      @(negedge clk);
      memReady = 1'b0;
      if (memReq === 1'b1) begin
        mem_cyc++;
        if (((gap_mode == 0) || (mem_cyc % 3 == 0)) && (mem_q.size() > 0)) begin
          chk("mem_addr", {480'd0, memAddr}, {480'd0, exp_maddr});
          memReady = 1'b1;
          memData  = mem_q.pop_front();
          beats_sent++;
        end
      end else begin
        mem_cyc = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (blkWrite === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_blkwrite: got lineSelect=%0h set=%0d expected no write", lineSelect, setSelect);
          end else begin
            mon_rec = exp_q.pop_front();
            chk("fill_set", {511'd0, setSelect}, {511'd0, mon_rec[545]});
            chk("fill_tag", {487'd0, tag}, {487'd0, mon_rec[544:520]});
            chk("fill_way", {504'd0, lineSelect}, {504'd0, mon_rec[519:512]});
            chk("fill_valid", {511'd0, valid}, 512'd1);
            chk("fill_data", blockData, mon_rec[511:0]);
          end
          for (int w = 0; w < 8; w++) begin
            if (lineSelect[w]) begin
              env_v[setSelect][w] = 1'b1;
              env_t[setSelect][w] = tag;
            end
          end
        end else begin
          chk("strobe_idle", {503'd0, valid, lineSelect}, 512'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic [31:0] addr, input int mode, input bit ramp);
    logic [24:0]  t;
    int           s;
    bit           hit;
    int           victim;
    logic [511:0] data;
    logic [31:0]  w32;
    int           stall_n;
    int           mreq_n;
    int           cyc;
    int           exp_stall;
    int           exp_mreq;
    t    = addr[31:7];
    s    = addr[6] ? 1 : 0;
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < 8; w++) begin
      if (ref_v[s][w] && (ref_t[s][w] == t)) hit = 1'b1;
    end
    if (!hit) begin
      victim = -1;
      for (int w = 7; w >= 0; w--) begin
        if (!ref_v[s][w]) victim = w;
      end
      if (victim < 0) begin
        victim    = ref_rr[s];
        ref_rr[s] = (ref_rr[s] + 1) % 8;
      end
      for (int k = 0; k < 16; k++) begin
        w32 = ramp ? 32'(k) : $urandom();
        mem_q.push_back(w32);
        data[32*k +: 32] = w32;
      end
      ref_v[s][victim] = 1'b1;
      ref_t[s][victim] = t;
      exp_q.push_back({addr[6], t, 8'(1 << victim), data});
    end
    exp_stall = hit ? 0 : ((mode != 0) ? 50 : 18);
    exp_mreq  = hit ? 0 : ((mode != 0) ? 48 : 16);

    exp_maddr = {addr[31:6], 6'b0};
    gap_mode  = mode;
    cpuAddr   = addr;
    cpuReq    = 1'b1;
    @(negedge clk);
    stall_n = 0;
    mreq_n  = 0;
    cyc     = 0;
    while ((stall === 1'b1) && (cyc < 400)) begin
      stall_n++;
      if (memReq === 1'b1) mreq_n++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: got stall still high after %0d cycles expected release for addr %h", cyc, addr);
    end
    chk("stall_cycles", 512'(stall_n), 512'(exp_stall));
    chk("memreq_cycles", 512'(mreq_n), 512'(exp_mreq));
    cpuReq = 1'b0;
    @(negedge clk);
    chk("idle_stall", {511'd0, stall}, 512'd0);
    chk("idle_memreq", {511'd0, memReq}, 512'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic reset_mid_fetch(input logic [31:0] addr);
    int cyc;
    for (int k = 0; k < 16; k++) mem_q.push_back($urandom());
    exp_maddr  = {addr[31:6], 6'b0};
    gap_mode   = 0;
    beats_sent = 0;
    cpuAddr    = addr;
    cpuReq     = 1'b1;
    cyc        = 0;
    while ((beats_sent < 8) && (cyc < 200)) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) begin
      checks++;
      failures++;
      $display("FAIL reset_beat_wait: got %0d beats expected 8", beats_sent);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_memreq", {511'd0, memReq}, 512'd0);
    chk("rst_blkwrite", {511'd0, blkWrite}, 512'd0);
    chk("rst_stall", {511'd0, stall}, 512'd0);
    chk("rst_blockdata", blockData, 512'd0);
    cpuReq = 1'b0;
    mem_q.delete();
    ref_rr[0] = 0;
    ref_rr[1] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    cpuReq     = 1'b0;
    cpuAddr    = '0;
    gap_mode   = 0;
    exp_maddr  = '0;
    beats_sent = 0;
    for (int s = 0; s < 2; s++) begin
      env_v[s]  = '0;
      ref_v[s]  = '0;
      ref_rr[s] = 0;
      for (int w = 0; w < 8; w++) begin
        env_t[s][w] = '0;
        ref_t[s][w] = '0;
      end
    end
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_memreq", {511'd0, memReq}, 512'd0);
    chk("reset_blkwrite", {511'd0, blkWrite}, 512'd0);
    chk("reset_linesel", {504'd0, lineSelect}, 512'd0);
    chk("reset_valid", {511'd0, valid}, 512'd0);
    chk("reset_stall", {511'd0, stall}, 512'd0);
    chk("reset_tag", {487'd0, tag}, 512'd0);
    chk("reset_set", {511'd0, setSelect}, 512'd0);
    chk("reset_blockdata", blockData, 512'd0);
    chk("reset_memaddr", {480'd0, memAddr}, 512'd0);
    reset = 1'b1;
    @(negedge clk);

    // Cold miss with ramp data, then hits on the same block.
    do_access(32'h0000_0080, 0, 1'b1);
    do_access(32'h0000_0084, 0, 1'b0);
    do_access(32'h0000_00BC, 0, 1'b0);

    // Full set 1: nine misses walk the round-robin pointer through a wrap.
    for (int w = 0; w < 8; w++) begin
      env_v[1][w] = 1'b1;
      env_t[1][w] = 25'h1000 + 25'(w);
      ref_v[1][w] = 1'b1;
      ref_t[1][w] = 25'h1000 + 25'(w);
    end
    for (int i = 0; i < 9; i++) begin
      do_access({25'h2000 + 25'(i), 1'b1, 6'h00}, 0, 1'b0);
    end
    do_access({25'h2008, 1'b1, 6'h10}, 0, 1'b0);

    // Memory beats arriving every third cycle.
    do_access(32'h0005_0000, 1, 1'b0);
    do_access(32'h0006_0040, 1, 1'b0);

    // Reset while half the block is fetched, then the same miss restarts cleanly.
    reset_mid_fetch(32'h0018_0000);
    do_access(32'h0018_0000, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      do_access({25'h40 + 25'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63))}, int'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", 512'(exp_q.size()), 512'd0);
    chk("mem_queue_empty", 512'(mem_q.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
